obstacle_gen: RTL and testbench



---
 rtl/obstacle_gen_if.sv | 20 ++
 rtl/obstacle_gen.sv | 136 +++++++++++++
 tb/tb_obstacle_gen.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/obstacle_gen_if.sv
// Link between the game controller and the obstacle generator:
// the game mode goes in; per-slot obstacle rectangles and the score come out.
interface obstacle_gen_if;
    logic [1:0]      gamemode;
    logic [9:0][9:0] obstacle_x_left;
    logic [9:0][9:0] obstacle_x_right;
    logic [9:0][8:0] obstacle_y_up;
    logic [9:0][8:0] obstacle_y_down;
    logic [9:0]      score;

    modport master (
        output gamemode,
        input  obstacle_x_left, obstacle_x_right, obstacle_y_up, obstacle_y_down, score
    );

    modport slave (
        input  gamemode,
        output obstacle_x_left, obstacle_x_right, obstacle_y_up, obstacle_y_down, score
    );
endinterface

// File: rtl/obstacle_gen.sv
// Ten-slot scrolling pillar generator with LFSR-chosen height and side,
// plus a saturating count of pillars that scroll past the player.
module obstacle_gen #(
    parameter int unsigned SCREEN_W       = 640,
    parameter int unsigned OBS_WIDTH      = 40,
    parameter int unsigned UPPER_BOUND    = 20,
    parameter int unsigned LOWER_BOUND    = 460,
    parameter int unsigned SCROLL_SPEED   = 4,
    parameter int unsigned SPAWN_INTERVAL = 45,
    parameter int unsigned PLAYER_X_LEFT  = 160,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input logic           clk,
    input logic           rst,
    obstacle_gen_if.slave bus
);
    localparam int NUM_SLOTS = 10;
    localparam int TIMER_W   = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;

    localparam logic [9:0]         SPEED_X    = 10'(SCROLL_SPEED);
    localparam logic [9:0]         SPAWN_XL   = 10'(SCREEN_W);
    localparam logic [9:0]         SPAWN_XR   = 10'(SCREEN_W + OBS_WIDTH);
    localparam logic [9:0]         SCORE_X    = 10'(PLAYER_X_LEFT);
    localparam logic [8:0]         TOP_Y      = 9'(UPPER_BOUND);
    localparam logic [8:0]         BOT_Y      = 9'(LOWER_BOUND);
    localparam logic [9:0]         SCORE_MAX  = 10'd999;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SPAWN_INTERVAL - 1);

    typedef enum logic [1:0] {
        GM_CLEAR = 2'b00,
        GM_PLAY  = 2'b01,
        GM_PAUSE = 2'b10,
        GM_CRASH = 2'b11
    } gamemode_e;

    typedef struct packed {
        logic       active;
        logic [9:0] x_left;
        logic [9:0] x_right;
        logic [8:0] y_up;
        logic [8:0] y_down;
    } slot_t;

    gamemode_e                  mode;
    slot_t [NUM_SLOTS-1:0]      slot_q, slot_d;
    logic  [TIMER_W-1:0]        timer_q, timer_d;
    logic  [9:0]                score_q, score_d;
    logic  [15:0]               lfsr_q, lfsr_d;
    logic  [3:0]                passed;
    logic  [10:0]               score_sum;
    logic  [8:0]                height;
    logic                       spawn_done;

    assign mode   = gamemode_e'(bus.gamemode);
    assign height = 9'd80 + {2'b00, lfsr_q[6:1], 1'b0};

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        lfsr_d     = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        slot_d     = slot_q;
        timer_d    = timer_q;
        score_d    = score_q;
        passed     = '0;
        score_sum  = '0;
        spawn_done = 1'b0;

        case (mode)
            GM_CLEAR: begin
                slot_d  = '0;
                timer_d = '0;
                score_d = '0;
            end
            GM_PLAY: begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (slot_q[i].active) begin
                        if (slot_q[i].x_right <= SPEED_X) begin
                            slot_d[i] = '0;
                        end else begin
                            slot_d[i].x_left  = (slot_q[i].x_left >= SPEED_X) ?
                                                slot_q[i].x_left - SPEED_X : '0;
                            slot_d[i].x_right = slot_q[i].x_right - SPEED_X;
                            if (slot_q[i].x_right > SCORE_X && slot_d[i].x_right <= SCORE_X)
                                passed = passed + 4'd1;
                        end
                    end
                end

                // Free slots are judged on pre-edge state, so a slot retired above stays empty this edge.
                if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (!spawn_done && !slot_q[i].active) begin
                            slot_d[i].active  = 1'b1;
                            slot_d[i].x_left  = SPAWN_XL;
                            slot_d[i].x_right = SPAWN_XR;
                            slot_d[i].y_up    = lfsr_q[0] ? BOT_Y - height : TOP_Y;
                            slot_d[i].y_down  = lfsr_q[0] ? BOT_Y : TOP_Y + height;
                            spawn_done        = 1'b1;
                        end
                    end
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end

                score_sum = {1'b0, score_q} + {7'b0, passed};
                score_d   = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[9:0];
            end
            default: ;  // pause and crashed hold everything except the LFSR
        endcase
    end

    // NOTE: state registers take non-blocking assignments; the combinational block uses blocking ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q  <= '0;
            timer_q <= '0;
            score_q <= '0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            slot_q  <= slot_d;
            timer_q <= timer_d;
            score_q <= score_d;
            lfsr_q  <= lfsr_d;
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_out
        assign bus.obstacle_x_left[g]  = slot_q[g].x_left;
        assign bus.obstacle_x_right[g] = slot_q[g].x_right;
        assign bus.obstacle_y_up[g]    = slot_q[g].y_up;
        assign bus.obstacle_y_down[g]  = slot_q[g].y_down;
    end

    assign bus.score = score_q;

endmodule

// File: tb/tb_obstacle_gen.sv
// Bench for obstacle_gen: a default instance and a fast-spawn instance
// (interval 1, speed 1), both checked every edge against a behavioural model.
module tb_obstacle_gen;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] gm0, gm1;

    int n_cmp = 0;
    int n_err = 0;

    int m_act [2][10];
    int m_xl  [2][10];
    int m_xr  [2][10];
    int m_yu  [2][10];
    int m_yd  [2][10];
    int m_score [2];
    int m_timer [2];
    int m_lfsr  [2];

    always #5 clk = ~clk;

    obstacle_gen_if if0 ();
    obstacle_gen_if if1 ();

    assign if0.gamemode = gm0;
    assign if1.gamemode = gm1;

    obstacle_gen dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    obstacle_gen #(
        .SPAWN_INTERVAL (1),
        .SCROLL_SPEED   (1)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int spd_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic int interval_of(input int k);
        return (k == 0) ? 45 : 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 10; i++) begin
                m_act[k][i] = 0; m_xl[k][i] = 0; m_xr[k][i] = 0;
                m_yu[k][i]  = 0; m_yd[k][i] = 0;
            end
            m_score[k] = 0;
            m_timer[k] = 0;
            m_lfsr[k]  = 'hACE1;
        end
    endtask

    task automatic model_step(input int k, input logic [1:0] gm);
        int free_q[$];
        int spd, h, old_xr, s, fb;
        spd = spd_of(k);
        h   = 80 + 2 * ((m_lfsr[k] >> 1) & 63);
        if (gm == 2'b00) begin
            for (int i = 0; i < 10; i++) begin
                m_act[k][i] = 0; m_xl[k][i] = 0; m_xr[k][i] = 0;
                m_yu[k][i]  = 0; m_yd[k][i] = 0;
            end
            m_score[k] = 0;
            m_timer[k] = 0;
        end else if (gm == 2'b01) begin
            for (int i = 0; i < 10; i++)
                if (m_act[k][i] == 0) free_q.push_back(i);
            for (int i = 0; i < 10; i++) begin
                if (m_act[k][i] != 0) begin
                    old_xr = m_xr[k][i];
                    if (old_xr <= spd) begin
                        m_act[k][i] = 0; m_xl[k][i] = 0; m_xr[k][i] = 0;
                        m_yu[k][i]  = 0; m_yd[k][i] = 0;
                    end else begin
                        m_xl[k][i] = (m_xl[k][i] >= spd) ? m_xl[k][i] - spd : 0;
                        m_xr[k][i] = old_xr - spd;
                        if (old_xr > 160 && m_xr[k][i] <= 160 && m_score[k] < 999)
                            m_score[k]++;
                    end
                end
            end
            if (m_timer[k] == interval_of(k) - 1) begin
                m_timer[k] = 0;
                if (free_q.size() > 0) begin
                    s = free_q[0];
                    m_act[k][s] = 1;
                    m_xl[k][s]  = 640;
                    m_xr[k][s]  = 680;
                    if ((m_lfsr[k] & 1) != 0) begin
                        m_yu[k][s] = 460 - h; m_yd[k][s] = 460;
                    end else begin
                        m_yu[k][s] = 20;      m_yd[k][s] = 20 + h;
                    end
                end
            end else begin
                m_timer[k]++;
            end
        end
        fb = (m_lfsr[k] ^ (m_lfsr[k] >> 2) ^ (m_lfsr[k] >> 3) ^ (m_lfsr[k] >> 5)) & 1;
        m_lfsr[k] = ((m_lfsr[k] >> 1) | (fb << 15)) & 'hFFFF;
    endtask

    task automatic compare_inst(input int k,
                                input logic [9:0][9:0] xl, input logic [9:0][9:0] xr,
                                input logic [9:0][8:0] yu, input logic [9:0][8:0] yd,
                                input logic [9:0] sc);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("i%0d_s%0d_xl", k, i), xl[i], m_xl[k][i]);
            check($sformatf("i%0d_s%0d_xr", k, i), xr[i], m_xr[k][i]);
            check($sformatf("i%0d_s%0d_yu", k, i), yu[i], m_yu[k][i]);
            check($sformatf("i%0d_s%0d_yd", k, i), yd[i], m_yd[k][i]);
        end
        check($sformatf("i%0d_score", k), sc, m_score[k]);
    endtask

    task automatic compare_all();
        compare_inst(0, if0.obstacle_x_left, if0.obstacle_x_right,
                     if0.obstacle_y_up, if0.obstacle_y_down, if0.score);
        compare_inst(1, if1.obstacle_x_left, if1.obstacle_x_right,
                     if1.obstacle_y_up, if1.obstacle_y_down, if1.score);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, gm0);
        model_step(1, gm1);
        #1;
        compare_all();
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [1:0] rand_gm();
        int r;
        r = $urandom_range(0, 999);
        if (r < 3)  return 2'b00;
        if (r < 40) return 2'b10;
        if (r < 70) return 2'b11;
        return 2'b01;
    endfunction

    initial begin
        rst = 1'b1;
        gm0 = 2'b00;
        gm1 = 2'b00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();

        @(negedge clk);
        rst = 1'b0;
        gm0 = 2'b01;
        gm1 = 2'b01;

        for (int e = 1; e <= 215; e++) begin
            tick();
            case (e)
                10: begin
                    check("fast_e10_s0_xl", if1.obstacle_x_left[0], 631);
                    check("fast_e10_s9_xl", if1.obstacle_x_left[9], 640);
                end
                11: begin
                    check("fast_e11_s0_xl", if1.obstacle_x_left[0], 630);
                    check("fast_e11_s9_xl", if1.obstacle_x_left[9], 639);
                end
                44: check("pre_spawn_s0_xr", if0.obstacle_x_right[0], 0);
                45: begin
                    check("spawn0_xl", if0.obstacle_x_left[0], 640);
                    check("spawn0_xr", if0.obstacle_x_right[0], 680);
                    check("spawn0_s1_xl", if0.obstacle_x_left[1], 0);
                end
                55: check("move_s0_xl", if0.obstacle_x_left[0], 600);
                90: begin
                    check("spawn1_xl", if0.obstacle_x_left[1], 640);
                    check("spawn1_s0_xl", if0.obstacle_x_left[0], 460);
                end
                174: check("pre_cross_score", if0.score, 0);
                175: begin
                    check("cross_s0_xr", if0.obstacle_x_right[0], 160);
                    check("cross_score", if0.score, 1);
                end
                214: check("last_s0_xr", if0.obstacle_x_right[0], 4);
                215: begin
                    check("retire_s0_xr", if0.obstacle_x_right[0], 0);
                    check("retire_s0_yd", if0.obstacle_y_down[0], 0);
                end
                default: ;
            endcase
        end

        gm0 = 2'b10; gm1 = 2'b10;
        repeat (10) tick();
        gm0 = 2'b11; gm1 = 2'b11;
        repeat (10) tick();
        check("hold_score", if0.score, 1);
        check("hold_s1_xr", if0.obstacle_x_right[1], 180);

        gm0 = 2'b01; gm1 = 2'b01;
        tick();
        check("resume_s1_xr", if0.obstacle_x_right[1], 176);
        repeat (5) tick();
        check("resume_s1_xr6", if0.obstacle_x_right[1], 156);
        check("resume_score", if0.score, 2);

        gm0 = 2'b00; gm1 = 2'b00;
        tick();
        check("clear_score0", if0.score, 0);
        check("clear_score1", if1.score, 0);
        check("clear_s1_xr", if0.obstacle_x_right[1], 0);

        gm0 = 2'b01; gm1 = 2'b01;
        repeat (45) tick();
        check("respawn_s0_xl", if0.obstacle_x_left[0], 640);

        for (int n = 0; n < 3000; n++) begin
            gm0 = rand_gm();
            gm1 = rand_gm();
            tick();
            if (n % 700 == 699) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
